// File: rtl/karatsuba_pkg.sv
// Shared types and widths for the Karatsuba recombination stage.
package karatsuba_pkg;

  localparam int unsigned HW  = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned PW  = 64;
  localparam int unsigned Z1W = 34;

  typedef enum logic [2:0] {
    IDLE,
    SUB1,
    SUB2,
    ADD_LO,
    ADD_HI,
    DONE
  } state_t;

endpackage

// File: rtl/karatsuba_recombine_if.sv
// Partial-product input and product output handshake bundle for karatsuba_recombine.
interface karatsuba_recombine_if;
  import karatsuba_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  z0;
  logic [AW-1:0]  z2;
  logic [Z1W-1:0] z1;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  product;
  logic           err;

  modport master (
    output in_valid, z0, z1, z2, out_ready,
    input  in_ready, out_valid, product, err
  );

  modport slave (
    input  in_valid, z0, z1, z2, out_ready,
    output in_ready, out_valid, product, err
  );

endinterface

// File: rtl/KOGGESTONE32BIT.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry in/out.
module KOGGESTONE32BIT (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] gg;
  logic [31:0] pp;

  // Five prefix levels at distances 1,2,4,8,16; cin is folded into bit 0's generate.
  always_comb begin
    logic [31:0] gn;
    logic [31:0] pn;
    logic [31:0] mask;
    pp    = a ^ b;
    gg    = a & b;
    gg[0] = gg[0] | (pp[0] & cin);
    for (int l = 0; l < 5; l++) begin
      mask = 32'((33'd1 << (1 << l)) - 33'd1);
      gn   = gg | (pp & (gg << (1 << l)));
      pn   = pp & ((pp << (1 << l)) | mask);
      gg   = gn;
      pp   = pn;
    end
    s    = (a ^ b) ^ {gg[30:0], cin};
    cout = gg[31];
  end

endmodule

// File: rtl/karatsuba_recombine.sv
// Sequential Karatsuba recombination: P = (z2<<32) + ((z1-z2-z0)<<16) + z0 over four adder passes.
// Optional consistency check on the middle term enabled by KARATSUBA_RECOMBINE_CHECK_EN.
module karatsuba_recombine #(
  parameter int unsigned HW = 16,
  parameter int unsigned AW = 32
) (
  input logic                 clk,
  input logic                 rst,
  karatsuba_recombine_if.slave bus
);
  import karatsuba_pkg::*;

  if (HW != karatsuba_pkg::HW || AW != karatsuba_pkg::AW) begin : g_bad_cfg
    $error("karatsuba_recombine: HW must be 16 and AW must be 32");
  end

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  z0_q;
  logic [AW-1:0]  z2_q;
  logic [Z1W-1:0] z1_q;
  logic [Z1W-1:0] mid;
  logic           c_lo;
  logic [PW-1:0]  product_q;
  logic           out_valid_q;
  logic           in_ready_q;

  logic [AW-1:0]  add_a;
  logic [AW-1:0]  add_b;
  logic [AW-1:0]  add_s;
  logic           add_ci;
  logic           add_co;
  logic [1:0]     mid_hi_base;
  logic [1:0]     mid_hi_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SUB1;
      SUB1:    state_nxt = SUB2;
      SUB2:    state_nxt = ADD_LO;
      ADD_LO:  state_nxt = ADD_HI;
      ADD_HI:  state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Adder operand selection per pass.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state)
      SUB1: begin
        add_a  = z1_q[AW-1:0];
        add_b  = ~z2_q;
        add_ci = 1'b1;
      end
      SUB2: begin
        add_a  = mid[AW-1:0];
        add_b  = ~z0_q;
        add_ci = 1'b1;
      end
      ADD_LO: begin
        add_a = {z2_q[HW-1:0], z0_q[AW-1:HW]};
        add_b = mid[AW-1:0];
      end
      ADD_HI: begin
        add_a  = {HW'(0), z2_q[AW-1:HW]};
        add_b  = {(AW-1)'(0), mid[AW]};
        add_ci = c_lo;
      end
      default: ;
    endcase
  end

  KOGGESTONE32BIT u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .s    (add_s),
    .cout (add_co)
  );

  // Two extension bits of the middle term track the borrow of each subtraction, modulo 4.
  assign mid_hi_base = (state == SUB1) ? z1_q[Z1W-1:AW] : mid[Z1W-1:AW];
  assign mid_hi_nxt  = mid_hi_base + {1'b0, add_co} + 2'b11;

  always_ff @(posedge clk) begin
    if (rst) begin
      z0_q        <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      mid         <= '0;
      c_lo        <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= (state_nxt == DONE);
      in_ready_q  <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            z0_q <= bus.z0;
            z1_q <= bus.z1;
            z2_q <= bus.z2;
          end
        end
        SUB1, SUB2: mid <= {mid_hi_nxt, add_s};
        ADD_LO: begin
          product_q[PW-HW-1:HW] <= add_s;
          product_q[HW-1:0]     <= z0_q[HW-1:0];
          c_lo                  <= add_co;
        end
        ADD_HI: product_q[PW-1:PW-HW] <= add_s[HW-1:0];
        default: ;
      endcase
    end
  end

`ifdef KARATSUBA_RECOMBINE_CHECK_EN
  logic err_q;

  // Sticky: a set top bit after the second subtraction means inconsistent partial products.
  always_ff @(posedge clk) begin
    if (rst)                                err_q <= 1'b0;
    else if (state == SUB2 && mid_hi_nxt[1]) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: doc/karatsuba_recombine.md
Name: karatsuba_recombine

Overview:
- Sequential recombination stage of the 32x32 Karatsuba multiplier; sits directly downstream of the three 16x16 partial-product multipliers.
- Computes P = (z2<<32) + ((z1 - z2 - z0)<<16) + z0 using a single instance of KOGGESTONE32BIT, time-shared over four passes.
- Produces a 64-bit product with a valid/ready handshake on both sides.

Parameters:
- HW, 16, half operand width. Fixed; elaboration error if not 16.
- AW, 32, adder width. Fixed at 32 to match KOGGESTONE32BIT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  partial products valid
- in_ready  out  1  block can accept; high only in IDLE
- z0  in  32  aL*bL
- z2  in  32  aH*bH
- z1  in  34  (aL+aH)*(bL+bH)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  64  recombined result
- err  out  1  sticky inconsistency flag; see Optional Feature

Behaviour:
- Reset values: out_valid=0, in_ready=1 (state IDLE), product=0, err=0. All internal registers cleared.
- FSM states: IDLE -> SUB1 -> SUB2 -> ADD_LO -> ADD_HI -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready, register z0, z1, z2 and go to SUB1. Inputs are ignored otherwise.
- SUB1: adder A=z1[31:0], B=~z2, Cin=1. mid[31:0]<=S. mid[33:32]<=z1[33:32]+Cout-1 (2-bit, modulo 4).
- SUB2: adder A=mid[31:0], B=~z0, Cin=1. mid[31:0]<=S. mid[33:32]<=mid[33:32]+Cout-1.
- ADD_LO: adder A={z2[15:0],z0[31:16]}, B=mid[31:0], Cin=0. product[47:16]<=S, product[15:0]<=z0[15:0], c_lo<=Cout.
- ADD_HI: adder A={16'b0,z2[31:16]}, B={31'b0,mid[32]}, Cin=c_lo. product[63:48]<=S[15:0].
- DONE: out_valid=1 and product stays stable until out_ready. On out_valid&&out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: the handshake accept edge is cycle 0; out_valid rises after cycle 5. Throughput is at most one product per 6 cycles (DONE->IDLE->accept). No overlap of operations.
- product holds its last value until overwritten in the next ADD_LO/ADD_HI; it is meaningful only while out_valid=1.
- out_ready asserted outside DONE has no effect. in_valid outside IDLE has no effect (in_ready=0).
- For valid inputs mid < 2^33, so mid[33]=0 always.
- Reset mid-operation, in any state: next cycle in IDLE, out_valid=0, the operation is discarded, err cleared.
- Single clock, no combinational path from inputs to outputs except through registers. in_ready is decoded from state.

Optional Feature:
- Macro: KARATSUBA_RECOMBINE_CHECK_EN.
- Defined: at the end of SUB2, if mid[33]==1 (negative or oversized middle term, i.e. inconsistent partial products), err is set and stays 1 until rst. The product is still computed and delivered normally.
- Undefined: err is tied to 0 and no check logic is generated. The port is present in both builds.

Decomposition:
- Shared package karatsuba_pkg holds:
  - state enum (IDLE, SUB1, SUB2, ADD_LO, ADD_HI, DONE)
  - constants HW=16, AW=32, PW=64, Z1W=34
- One sub-module: the existing KOGGESTONE32BIT. Its operands are muxed by state.
- The 2-bit mid-extension logic stays inline.

Test Plan:
- Small values: a=0x00010002, b=0x00030004 gives z2=3, z0=8, z1=21. Expect product=0x00000003000A0008, out_valid 5 cycles after accept.
- All-ones: z0=z2=0xFFFE0001, z1=0x3FFF80004. Expect product=0xFFFFFFFE00000001, err=0. Exercises mid[32]=1 and c_lo propagation.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. product stable, in_ready=0, and a new in_valid is ignored. Release gives a single out transfer, then in_ready=1.
- Reset in ADD_LO: assert rst one cycle. Next cycle state IDLE, out_valid=0, in_ready=1. A following operation (zeros: z0=z1=z2=0) yields product=0.
- Check feature (macro defined): z0=5, z2=5, z1=4 gives mid negative. err=1 after SUB2 and stays 1 through subsequent valid ops until rst. Macro undefined: err stays 0.
- Random: 1000 random a, b with partial products from a golden model. product==a*b, err never set, accept-to-valid latency always 5.
